fwd_hazard_ctrl: RTL and testbench

//  Forwarding and hazard control for the 5-stage pipeline, parametrised in register-address width and source-operand count.
//  Per-operand EX/MEM and MEM/WB forwarding select, independent per operand.

---
 rtl/fwd_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - forwarding select, load-use stall and memory-freeze control for a 5-stage pipe
module fwd_hazard_ctrl #(
  parameter int AW         = 5,
  parameter int NSRC       = 2,
  parameter int LU_BUBBLES = 1,
  parameter int MEM_TMO    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NSRC*AW-1:0]   ex_src_addr_i,
  input  logic [NSRC*AW-1:0]   id_src_addr_i,
  input  logic [NSRC-1:0]      id_src_used_i,
  input  logic [AW-1:0]        idex_waddr_i,
  input  logic                 idex_memread_i,
  input  logic [AW-1:0]        exmem_waddr_i,
  input  logic                 exmem_regwrite_i,
  input  logic [AW-1:0]        memwb_waddr_i,
  input  logic                 memwb_regwrite_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_ack_i,
  input  logic                 cnt_clr_i,
  output logic [2*NSRC-1:0]    fwd_sel_o,
  output logic                 pc_write_o,
  output logic                 ifid_write_o,
  output logic                 idex_bubble_o,
  output logic                 freeze_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic                 err_o
);

  localparam int TW = $clog2(MEM_TMO + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(MEM_TMO);
  localparam logic [3:0]    LU_INIT = 4'(LU_BUBBLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        lu_cnt_q, lu_cnt_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [2*NSRC-1:0] fwd_sel_c;
  logic              pc_write_c, ifid_write_c, bubble_c;
  logic              mb;
  logic              lu_hz;

  assign mb = dmem_req_i & ~dmem_ack_i;

  // Per-operand forwarding; EX/MEM has priority, r0 never forwards.
  for (genvar k = 0; k < NSRC; k++) begin : g_fwd
    logic [AW-1:0] src;
    logic          ex_hit, wb_hit;
    assign src    = ex_src_addr_i[k*AW +: AW];
    assign ex_hit = exmem_regwrite_i && (exmem_waddr_i != '0) && (exmem_waddr_i == src);
    assign wb_hit = memwb_regwrite_i && (memwb_waddr_i != '0) && (memwb_waddr_i == src);
    assign fwd_sel_c[2*k +: 2] = ex_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
  end

  // Load-use detection: a load in ID/EX whose target is read by the ID instruction.
  always_comb begin
    lu_hz = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (id_src_used_i[k] && (id_src_addr_i[k*AW +: AW] == idex_waddr_i)) begin
        lu_hz = 1'b1;
      end
    end
    lu_hz = lu_hz & idex_memread_i & (idex_waddr_i != '0);
  end

  // Next-state and pipeline-control decode; a busy memory freezes everything.
  always_comb begin
    state_d      = state_q;
    lu_cnt_d     = lu_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = err_q;
    pc_write_c   = 1'b0;
    ifid_write_c = 1'b0;
    bubble_c     = 1'b0;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mb) begin
          state_d = ST_MEM_WAIT;
          if (state_q == ST_RUN) begin
            tmo_cnt_d = TW'(1);
          end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
        end else begin
          // Ack cycle (or request withdrawn) behaves exactly like RUN.
          state_d   = ST_RUN;
          tmo_cnt_d = '0;
          if (lu_hz) begin
            bubble_c = 1'b1;
            if (LU_BUBBLES > 1) begin
              state_d  = ST_LU_STALL;
              lu_cnt_d = LU_INIT;
            end
          end else begin
            pc_write_c   = 1'b1;
            ifid_write_c = 1'b1;
          end
        end
      end
      ST_LU_STALL: begin
        if (!mb) begin
          bubble_c = 1'b1;
          lu_cnt_d = lu_cnt_q - 4'd1;
          if (lu_cnt_q == 4'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
    if ((state_d == ST_MEM_WAIT) && (tmo_cnt_d == TMO_MAX)) begin
      err_d = 1'b1;
    end
  end

  // Saturating count of cycles where the PC is held; clear has priority.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
    end else if (!pc_write_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_RUN;
      lu_cnt_q    <= '0;
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_sel_o     = rst_i ? fwd_sel_c : '0;
  assign pc_write_o    = rst_i & pc_write_c;
  assign ifid_write_o  = rst_i & ifid_write_c;
  assign idex_bubble_o = rst_i & bubble_c;
  assign freeze_o      = rst_i & mb;
  assign stall_cnt_o   = stall_cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed vector bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  ex_src_addr_i;
  logic [9:0]  id_src_addr_i;
  logic [1:0]  id_src_used_i;
  logic [4:0]  idex_waddr_i;
  logic        idex_memread_i;
  logic [4:0]  exmem_waddr_i;
  logic        exmem_regwrite_i;
  logic [4:0]  memwb_waddr_i;
  logic        memwb_regwrite_i;
  logic        dmem_req_i;
  logic        dmem_ack_i;
  logic        cnt_clr_i;
  logic [3:0]  fwd_sel_o;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        idex_bubble_o;
  logic        freeze_o;
  logic [15:0] stall_cnt_o;
  logic        err_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_ctrl #(
    .AW(5), .NSRC(2), .LU_BUBBLES(2), .MEM_TMO(4), .CNT_W(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_src_addr_i(ex_src_addr_i), .id_src_addr_i(id_src_addr_i),
    .id_src_used_i(id_src_used_i), .idex_waddr_i(idex_waddr_i),
    .idex_memread_i(idex_memread_i), .exmem_waddr_i(exmem_waddr_i),
    .exmem_regwrite_i(exmem_regwrite_i), .memwb_waddr_i(memwb_waddr_i),
    .memwb_regwrite_i(memwb_regwrite_i), .dmem_req_i(dmem_req_i),
    .dmem_ack_i(dmem_ack_i), .cnt_clr_i(cnt_clr_i),
    .fwd_sel_o(fwd_sel_o), .pc_write_o(pc_write_o),
    .ifid_write_o(ifid_write_o), .idex_bubble_o(idex_bubble_o),
    .freeze_o(freeze_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  typedef struct {
    logic [9:0] ex_src;
    logic [4:0] exmem_wa;
    logic       exmem_rw;
    logic [4:0] memwb_wa;
    logic       memwb_rw;
    logic [9:0] id_src;
    logic [1:0] id_used;
    logic [4:0] idex_wa;
    logic       idex_rd;
    logic [3:0] exp_fwd;
    logic       exp_pcw;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_in();
    ex_src_addr_i    = '0;
    id_src_addr_i    = '0;
    id_src_used_i    = '0;
    idex_waddr_i     = '0;
    idex_memread_i   = 1'b0;
    exmem_waddr_i    = '0;
    exmem_regwrite_i = 1'b0;
    memwb_waddr_i    = '0;
    memwb_regwrite_i = 1'b0;
    dmem_req_i       = 1'b0;
    dmem_ack_i       = 1'b0;
    cnt_clr_i        = 1'b0;
  endtask

  task automatic set_lu();
    idex_waddr_i   = 5'd5;
    idex_memread_i = 1'b1;
    id_src_addr_i  = {5'd0, 5'd5};
    id_src_used_i  = 2'b01;
  endtask

  initial begin
    //           ex_src           exwa  exrw memwa wbrw id_src           used   idwa  rd    fwd      pcw
    vt[0] = '{{5'd7, 5'd3}, 5'd3, 1'b1, 5'd3, 1'b1, {5'd0, 5'd0}, 2'b00, 5'd0, 1'b0, 4'b0010, 1'b1};
    vt[1] = '{{5'd7, 5'd3}, 5'd0, 1'b1, 5'd3, 1'b1, {5'd0, 5'd5}, 2'b00, 5'd5, 1'b1, 4'b0001, 1'b1};
    vt[2] = '{{5'd0, 5'd3}, 5'd0, 1'b1, 5'd3, 1'b1, {5'd0, 5'd0}, 2'b00, 5'd0, 1'b0, 4'b0001, 1'b1};
    vt[3] = '{{5'd9, 5'd3}, 5'd9, 1'b1, 5'd3, 1'b1, {5'd5, 5'd0}, 2'b01, 5'd5, 1'b1, 4'b1001, 1'b1};
    vt[4] = '{{5'd3, 5'd3}, 5'd3, 1'b0, 5'd3, 1'b0, {5'd0, 5'd0}, 2'b11, 5'd0, 1'b1, 4'b0000, 1'b1};
    vt[5] = '{{5'd4, 5'd4}, 5'd4, 1'b1, 5'd0, 1'b0, {5'd7, 5'd6}, 2'b11, 5'd5, 1'b1, 4'b1010, 1'b1};
    vt[6] = '{{5'd0, 5'd0}, 5'd0, 1'b1, 5'd0, 1'b1, {5'd0, 5'd0}, 2'b00, 5'd0, 1'b0, 4'b0000, 1'b1};
    vt[7] = '{{5'd6, 5'd6}, 5'd6, 1'b0, 5'd6, 1'b1, {5'd0, 5'd0}, 2'b00, 5'd0, 1'b0, 4'b0101, 1'b1};

    clr_in();
    rst_i = 1'b0;
    #2;
    ex_src_addr_i    = {5'd7, 5'd3};
    exmem_waddr_i    = 5'd3;
    exmem_regwrite_i = 1'b1;
    dmem_req_i       = 1'b1;
    #1;
    chk("rst_fwd", 32'(fwd_sel_o), 32'h0);
    chk("rst_pcw", 32'(pc_write_o), 32'h0);
    chk("rst_freeze", 32'(freeze_o), 32'h0);
    chk("rst_cnt", 32'(stall_cnt_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    clr_in();
    tick();
    rst_i = 1'b1;

    for (int i = 0; i < 8; i++) begin
      ex_src_addr_i    = vt[i].ex_src;
      exmem_waddr_i    = vt[i].exmem_wa;
      exmem_regwrite_i = vt[i].exmem_rw;
      memwb_waddr_i    = vt[i].memwb_wa;
      memwb_regwrite_i = vt[i].memwb_rw;
      id_src_addr_i    = vt[i].id_src;
      id_src_used_i    = vt[i].id_used;
      idex_waddr_i     = vt[i].idex_wa;
      idex_memread_i   = vt[i].idex_rd;
      #3;
      chk($sformatf("vec%0d_fwd", i), 32'(fwd_sel_o), 32'(vt[i].exp_fwd));
      chk($sformatf("vec%0d_pcw", i), 32'(pc_write_o), 32'(vt[i].exp_pcw));
      chk($sformatf("vec%0d_bub", i), 32'(idex_bubble_o), 32'(!vt[i].exp_pcw));
      tick();
    end
    chk("vec_cnt", 32'(stall_cnt_o), 32'h0);
    clr_in();

    // load-use with two bubbles
    set_lu();
    #3;
    chk("lu_bub1", 32'(idex_bubble_o), 32'h1);
    chk("lu_pcw1", 32'(pc_write_o), 32'h0);
    chk("lu_ifid1", 32'(ifid_write_o), 32'h0);
    tick();
    idex_memread_i = 1'b0;
    #3;
    chk("lu_bub2", 32'(idex_bubble_o), 32'h1);
    chk("lu_pcw2", 32'(pc_write_o), 32'h0);
    tick();
    #3;
    chk("lu_bub3", 32'(idex_bubble_o), 32'h0);
    chk("lu_pcw3", 32'(pc_write_o), 32'h1);
    chk("lu_cnt", 32'(stall_cnt_o), 32'd2);
    tick();
    clr_in();

    // memory busy for three cycles, then ack
    dmem_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk($sformatf("mb_frz%0d", i), 32'(freeze_o), 32'h1);
      chk($sformatf("mb_pcw%0d", i), 32'(pc_write_o), 32'h0);
      tick();
    end
    dmem_ack_i = 1'b1;
    #3;
    chk("mb_ack_frz", 32'(freeze_o), 32'h0);
    chk("mb_ack_pcw", 32'(pc_write_o), 32'h1);
    tick();
    clr_in();
    chk("mb_err", 32'(err_o), 32'h0);
    chk("mb_cnt", 32'(stall_cnt_o), 32'd5);

    // busy memory during the second load-use bubble
    set_lu();
    #3;
    chk("lb_bub1", 32'(idex_bubble_o), 32'h1);
    tick();
    idex_memread_i = 1'b0;
    dmem_req_i     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk($sformatf("lb_frz%0d", i), 32'(freeze_o), 32'h1);
      chk($sformatf("lb_bub_hold%0d", i), 32'(idex_bubble_o), 32'h0);
      tick();
    end
    dmem_ack_i = 1'b1;
    #3;
    chk("lb_ack_frz", 32'(freeze_o), 32'h0);
    chk("lb_ack_bub", 32'(idex_bubble_o), 32'h1);
    chk("lb_ack_pcw", 32'(pc_write_o), 32'h0);
    tick();
    dmem_req_i = 1'b0;
    dmem_ack_i = 1'b0;
    #3;
    chk("lb_run_bub", 32'(idex_bubble_o), 32'h0);
    chk("lb_run_pcw", 32'(pc_write_o), 32'h1);
    chk("lb_cnt", 32'(stall_cnt_o), 32'd9);
    tick();
    clr_in();

    // clear coinciding with a stall cycle
    set_lu();
    cnt_clr_i = 1'b1;
    #3;
    chk("clr_bub", 32'(idex_bubble_o), 32'h1);
    tick();
    chk("clr_cnt0", 32'(stall_cnt_o), 32'h0);
    cnt_clr_i      = 1'b0;
    idex_memread_i = 1'b0;
    tick();
    chk("clr_cnt1", 32'(stall_cnt_o), 32'h1);
    #2;
    chk("clr_pcw", 32'(pc_write_o), 32'h1);
    tick();
    clr_in();

    // memory never acks: timeout after four frozen cycles
    dmem_req_i = 1'b1;
    repeat (3) tick();
    chk("tmo_err3", 32'(err_o), 32'h0);
    tick();
    chk("tmo_err4", 32'(err_o), 32'h1);
    repeat (5) tick();
    chk("tmo_err_sticky", 32'(err_o), 32'h1);
    chk("tmo_frz", 32'(freeze_o), 32'h1);
    rst_i = 1'b0;
    #1;
    chk("tmo_rst_err", 32'(err_o), 32'h0);
    chk("tmo_rst_frz", 32'(freeze_o), 32'h0);
    chk("tmo_rst_cnt", 32'(stall_cnt_o), 32'h0);
    dmem_req_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #3;
    chk("post_rst_pcw", 32'(pc_write_o), 32'h1);
    chk("post_rst_err", 32'(err_o), 32'h0);
    tick();
    chk("post_rst_cnt", 32'(stall_cnt_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
